// File: rtl/affine_arbiter.sv
// Round-robin arbiter sharing one affine_transform datapath among NREQ requesters,
// with a single-entry registered output stage. Optional: AFFINE_ARB_ZEROIZE_EN.

package types;
    parameter int d = 1;
    localparam int SW = 8 * (d + 1);
    typedef logic [SW-1:0] state_t;
    typedef logic [SW-1:0][SW-1:0] rr_matrix_t;
endpackage

module affine_transform #(
    parameter int W = 16
) (
    input  logic [W-1:0][W-1:0] mat,
    input  logic [W-1:0]        x,
    input  logic [W-1:0]        t,
    output logic [W-1:0]        y
);
    // Row i of mat selects the operand bits that are XOR-summed into y[i].
    always_comb begin
        y = '0;
        for (int i = 0; i < W; i++) begin
            y[i] = (^(mat[i] & x)) ^ t[i];
        end
    end
endmodule

module affine_arbiter #(
    parameter int d    = types::d,
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NREQ-1:0]                             req_valid,
    output logic [NREQ-1:0]                             req_ready,
    input  logic [NREQ-1:0][8*(d+1)-1:0]                req_in,
    input  logic [NREQ-1:0][8*(d+1)-1:0][8*(d+1)-1:0]   req_T,
    input  logic [NREQ-1:0][8*(d+1)-1:0]                req_t,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [8*(d+1)-1:0]                          out_data,
    output logic [IDW-1:0]                              out_id
);
    localparam int SW = 8 * (d + 1);

    // Handshakes: a beat moves on a channel only in a cycle where valid and
    // ready are both high; req_ready may depend on req_valid, never the reverse.

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                  state;
    logic [IDW-1:0]          rr_ptr;
    logic                    can_accept;
    logic                    gnt_found;
    logic [IDW-1:0]          gnt_idx;
    logic                    transfer;
    logic [SW-1:0][SW-1:0]   sel_T;
    logic [SW-1:0]           sel_x;
    logic [SW-1:0]           sel_t;
    logic [SW-1:0]           xf_y;

    assign can_accept = (state == EMPTY) | out_ready;

    // First pending requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        if (can_accept && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (!gnt_found && req_valid[idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);

    always_comb begin
`ifdef AFFINE_ARB_ZEROIZE_EN
        sel_T = '0;
        sel_x = '0;
        sel_t = '0;
        if (gnt_found) begin
            sel_T = req_T[gnt_idx];
            sel_x = req_in[gnt_idx];
            sel_t = req_t[gnt_idx];
        end
`else
        sel_T = req_T[gnt_idx];
        sel_x = req_in[gnt_idx];
        sel_t = req_t[gnt_idx];
`endif
    end

    affine_transform #(.W(SW)) u_xf (
        .mat (sel_T),
        .x   (sel_x),
        .t   (sel_t),
        .y   (xf_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (transfer) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= xf_y;
            out_id    <= gnt_idx;
            rr_ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end else if (state == FULL && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
`ifdef AFFINE_ARB_ZEROIZE_EN
            out_data  <= '0;
            out_id    <= '0;
`endif
        end
    end
endmodule
